// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared cause codes, FSM encodings and CSR bit indices for trap_ctrl
package trap_ctrl_pkg;

    localparam logic [31:0] CAUSE_INST_MISALIGN = 32'h0000_0000;
    localparam logic [31:0] CAUSE_ILLEGAL       = 32'h0000_0002;
    localparam logic [31:0] CAUSE_BREAKPOINT    = 32'h0000_0003;
    localparam logic [31:0] CAUSE_LD_MISALIGN   = 32'h0000_0004;
    localparam logic [31:0] CAUSE_ST_MISALIGN   = 32'h0000_0006;
    localparam logic [31:0] CAUSE_ECALL_M       = 32'h0000_000B;
    localparam logic [31:0] CAUSE_M_EXT_IRQ     = 32'h8000_000B;

    localparam int MSTATUS_MIE = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_RET      = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// rtl/trap_ctrl_irq_sync.sv - irq_sync: 2-flop synchroniser with rising-edge pulse
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic irq_rise
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Two flops resolve metastability, the third remembers the previous level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= irq_async;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign irq_rise = sync_q2 & ~sync_q3;

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer (optional TRAP_VECTORED_EN for vectored interrupts)
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] inst_mem,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            inst_misalign,
    input  logic            illegal,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            ld_misalign,
    input  logic            st_misalign,
    input  logic            mret_mem,
    input  logic            ext_irq,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            trap,
    output logic            mret,
    output logic [XLEN-1:0] mepc_out,
    output logic [XLEN-1:0] mcause_out,
    output logic [XLEN-1:0] mtval_out,
    output logic            flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_t     state;
    logic            irq_rise;
    logic            irq_pend;
    logic            irq_take;
    logic            ev_trap;
    logic            ev_ret;
    logic [XLEN-1:0] ev_cause;
    logic [XLEN-1:0] ev_tval;
    logic            take_trap;
    logic            take_ret;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;
    logic            unused_ok;

    irq_sync u_irq_sync (
        .clk       (clk),
        .rst       (rst),
        .irq_async (ext_irq),
        .irq_rise  (irq_rise)
    );

    assign irq_take = irq_pend & mstatus[MSTATUS_MIE];

    // Priority encode the MEM-stage events; interrupt first so a faulting instruction re-executes later
    always_comb begin
        ev_trap  = 1'b0;
        ev_ret   = 1'b0;
        ev_cause = '0;
        ev_tval  = '0;
        if (irq_take) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_M_EXT_IRQ;
        end else if (inst_misalign) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_INST_MISALIGN;
            ev_tval  = pc_mem;
        end else if (illegal) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_ILLEGAL;
            ev_tval  = inst_mem;
        end else if (ebreak) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_BREAKPOINT;
            ev_tval  = pc_mem;
        end else if (ecall) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_ECALL_M;
        end else if (ld_misalign) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_LD_MISALIGN;
            ev_tval  = mem_addr;
        end else if (st_misalign) begin
            ev_trap  = 1'b1;
            ev_cause = CAUSE_ST_MISALIGN;
            ev_tval  = mem_addr;
        end else if (mret_mem) begin
            ev_ret   = 1'b1;
        end
    end

    assign take_trap = (state == ST_IDLE) & valid_mem & ev_trap;
    assign take_ret  = (state == ST_IDLE) & valid_mem & ev_ret;
    assign flush     = (state != ST_IDLE) | take_trap | take_ret;

    // Target uses the cause latched in mcause_out while in TRAP
    assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_target = (mcause_out[XLEN-1] && (mtvec_in[1:0] == 2'b01))
                       ? trap_base + {mcause_out[XLEN-3:0], 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    assign unused_ok = ^{mstatus, mtvec_in[1:0], mcause_out[XLEN-2]};

    // Pending latch: cleared when the interrupt is taken, otherwise set by a synchronised rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend <= 1'b0;
        end else if (take_trap && irq_take) begin
            irq_pend <= 1'b0;
        end else if (irq_rise) begin
            irq_pend <= 1'b1;
        end
    end

    // Sequencer FSM with registered CSR strobes and redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            trap        <= 1'b0;
            mret        <= 1'b0;
            mepc_out    <= '0;
            mcause_out  <= '0;
            mtval_out   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            trap     <= 1'b0;
            mret     <= 1'b0;
            redirect <= 1'b0;
            case (state)
                ST_IDLE: begin
                    redirect_pc <= '0;
                    if (take_trap) begin
                        state      <= ST_TRAP;
                        trap       <= 1'b1;
                        mepc_out   <= pc_mem;
                        mcause_out <= ev_cause;
                        mtval_out  <= ev_tval;
                    end else if (take_ret) begin
                        state      <= ST_RET;
                        mret       <= 1'b1;
                        mepc_out   <= mepc_in;
                        mcause_out <= '0;
                        mtval_out  <= '0;
                    end
                end
                ST_TRAP: begin
                    state       <= ST_REDIRECT;
                    redirect    <= 1'b1;
                    redirect_pc <= trap_target;
                    mepc_out    <= '0;
                    mcause_out  <= '0;
                    mtval_out   <= '0;
                end
                ST_RET: begin
                    state       <= ST_REDIRECT;
                    redirect    <= 1'b1;
                    redirect_pc <= mepc_in;
                    mepc_out    <= '0;
                end
                default: begin
                    state       <= ST_IDLE;
                    redirect_pc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed table-driven bench for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem;
    logic [31:0] pc_mem, inst_mem, mem_addr;
    logic        inst_misalign, illegal, ecall, ebreak, ld_misalign, st_misalign, mret_mem;
    logic        ext_irq;
    logic [31:0] mstatus, mtvec_in, mepc_in;
    logic        trap, mret, flush, redirect;
    logic [31:0] mepc_out, mcause_out, mtval_out, redirect_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .pc_mem(pc_mem),
        .inst_mem(inst_mem), .mem_addr(mem_addr), .inst_misalign(inst_misalign),
        .illegal(illegal), .ecall(ecall), .ebreak(ebreak), .ld_misalign(ld_misalign),
        .st_misalign(st_misalign), .mret_mem(mret_mem), .ext_irq(ext_irq),
        .mstatus(mstatus), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .trap(trap),
        .mret(mret), .mepc_out(mepc_out), .mcause_out(mcause_out), .mtval_out(mtval_out),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // flags order: inst_misalign, illegal, ecall, ebreak, ld_misalign, st_misalign, mret_mem
    typedef struct {
        logic [6:0]  flags;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        is_ret;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] epc;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [6:0] f);
        {inst_misalign, illegal, ecall, ebreak, ld_misalign, st_misalign, mret_mem} = f;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        valid_mem = 1'b1; set_flags(v.flags);
        pc_mem = v.pc; inst_mem = v.inst; mem_addr = v.addr;
        mtvec_in = v.mtvec; mepc_in = v.mepc; mstatus = 32'h0;
        #1;
        chk({tag, "_n_flush"}, {31'b0, flush}, 32'd1);
        chk({tag, "_n_trap"}, {31'b0, trap}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_n1_trap"}, {31'b0, trap}, {31'b0, ~v.is_ret});
        chk({tag, "_n1_mret"}, {31'b0, mret}, {31'b0, v.is_ret});
        chk({tag, "_n1_mepc"}, mepc_out, v.epc);
        chk({tag, "_n1_mcause"}, mcause_out, v.cause);
        chk({tag, "_n1_mtval"}, mtval_out, v.tval);
        chk({tag, "_n1_flush"}, {31'b0, flush}, 32'd1);
        chk({tag, "_n1_redirect"}, {31'b0, redirect}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_n2_redirect"}, {31'b0, redirect}, 32'd1);
        chk({tag, "_n2_rpc"}, redirect_pc, v.rpc);
        chk({tag, "_n2_strobes"}, {30'b0, trap, mret}, 32'd0);
        chk({tag, "_n2_flush"}, {31'b0, flush}, 32'd1);
        @(negedge clk);
        valid_mem = 1'b0; set_flags(7'b0);
        #1;
        chk({tag, "_n3_flush"}, {31'b0, flush}, 32'd0);
        chk({tag, "_n3_redirect"}, {31'b0, redirect}, 32'd0);
    endtask

    // Observe a trap beginning this cycle and check the two following cycles
    task automatic check_irq_seq(input string tag, input logic [31:0] epc, input logic [31:0] rpc);
        @(negedge clk); #1;
        chk({tag, "_trap"}, {31'b0, trap}, 32'd1);
        chk({tag, "_mcause"}, mcause_out, 32'h8000_000B);
        chk({tag, "_mtval"}, mtval_out, 32'h0);
        chk({tag, "_mepc"}, mepc_out, epc);
        @(negedge clk); #1;
        chk({tag, "_redirect"}, {31'b0, redirect}, 32'd1);
        chk({tag, "_rpc"}, redirect_pc, rpc);
    endtask

    initial begin
        int hits;
        logic found;
        logic [31:0] irq_rpc;

        vecs[0] = '{7'b0100000, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h0, 1'b0, 32'd2, 32'hFFFF_FFFF, 32'h100, 32'h200};
        vecs[1] = '{7'b0010100, 32'h104, 32'h0, 32'h1003, 32'h200, 32'h0, 1'b0, 32'd11, 32'h0, 32'h104, 32'h200};
        vecs[2] = '{7'b0000001, 32'h300, 32'h0, 32'h0, 32'h200, 32'h104, 1'b1, 32'd0, 32'h0, 32'h104, 32'h104};
        vecs[3] = '{7'b1100000, 32'h202, 32'h1234, 32'h0, 32'h301, 32'h0, 1'b0, 32'd0, 32'h202, 32'h202, 32'h300};
        vecs[4] = '{7'b0011000, 32'h300, 32'h0, 32'h0, 32'h400, 32'h0, 1'b0, 32'd3, 32'h300, 32'h300, 32'h400};
        vecs[5] = '{7'b0000100, 32'h500, 32'h0, 32'h1003, 32'h403, 32'h0, 1'b0, 32'd4, 32'h1003, 32'h500, 32'h400};
        vecs[6] = '{7'b0000010, 32'h504, 32'h0, 32'h2002, 32'h800, 32'h0, 1'b0, 32'd6, 32'h2002, 32'h504, 32'h800};
        vecs[7] = '{7'b0000011, 32'h508, 32'h0, 32'h2006, 32'h800, 32'h99, 1'b0, 32'd6, 32'h2006, 32'h508, 32'h800};

        rst = 1'b1; valid_mem = 1'b0; set_flags(7'b0);
        pc_mem = '0; inst_mem = '0; mem_addr = '0; ext_irq = 1'b0;
        mstatus = '0; mtvec_in = '0; mepc_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {28'b0, trap, mret, flush, redirect}, 32'd0);
        chk("reset_data", mepc_out | mcause_out | mtval_out | redirect_pc, 32'd0);
        @(negedge clk); rst = 1'b0;

        // An instruction with no event, and a flagged bubble, must not start a sequence
        @(negedge clk); valid_mem = 1'b1; #1;
        chk("no_event_flush", {31'b0, flush}, 32'd0);
        @(negedge clk); valid_mem = 1'b0; illegal = 1'b1; #1;
        chk("bubble_flush", {31'b0, flush}, 32'd0);
        @(negedge clk); illegal = 1'b0; #1;
        chk("bubble_trap", {31'b0, trap}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Interrupt with MIE=1: vectored target only when the feature is built in
`ifdef TRAP_VECTORED_EN
        irq_rpc = 32'h22C;
`else
        irq_rpc = 32'h200;
`endif
        @(negedge clk);
        mstatus = 32'h8; mtvec_in = 32'h201; pc_mem = 32'h40; valid_mem = 1'b1; ext_irq = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (flush) found = 1'b1;
            else @(negedge clk);
        end
        chk("irq_taken", {31'b0, found}, 32'd1);
        if (found) check_irq_seq("irq", 32'h40, irq_rpc);
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (trap) hits++;
        end
        chk("irq_pend_cleared", hits, 32'd0);

        // Interrupt with MIE=0 is held pending until MIE is set
        @(negedge clk); ext_irq = 1'b0; valid_mem = 1'b0; mstatus = 32'h0;
        repeat (5) @(negedge clk);
        ext_irq = 1'b1; valid_mem = 1'b1; pc_mem = 32'h80; mtvec_in = 32'h200;
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (flush) hits++;
        end
        chk("mie0_no_trap", hits, 32'd0);
        @(negedge clk); mstatus = 32'h8; #1;
        chk("mie1_flush", {31'b0, flush}, 32'd1);
        check_irq_seq("held_irq", 32'h80, 32'h200);
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (flush) hits++;
        end
        chk("held_pend_cleared", hits, 32'd0);

        // Reset during N+1 aborts the sequence immediately
        @(negedge clk); valid_mem = 1'b0; ext_irq = 1'b0; mstatus = 32'h0;
        repeat (4) @(negedge clk);
        valid_mem = 1'b1; illegal = 1'b1; pc_mem = 32'h100; inst_mem = 32'hFFFF_FFFF;
        @(negedge clk); valid_mem = 1'b0; illegal = 1'b0; #1;
        chk("rst_pre_trap", {31'b0, trap}, 32'd1);
        #1 rst = 1'b1; #1;
        chk("rst_async_outs", {28'b0, trap, mret, flush, redirect}, 32'd0);
        chk("rst_async_data", mepc_out | mcause_out | mtval_out, 32'd0);
        @(negedge clk); rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (trap || redirect || flush) hits++;
        end
        chk("rst_no_residue", hits, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting between the MEM stage and the CSR register file. It prioritises synchronous exceptions, a synchronised external interrupt and `mret` for the instruction in MEM. It drives the CSR trap/mret update ports (`trap`, `mret`, `mepc`, `mcause`, `mtval`), then issues a pipeline flush and a PC redirect to `mtvec` or `mepc`.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `valid_mem`  in  1  MEM holds a real (non-bubble) instruction
- `pc_mem`  in  32  PC of MEM instruction
- `inst_mem`  in  32  instruction word
- `mem_addr`  in  32  effective load/store address
- `inst_misalign`, `illegal`, `ecall`, `ebreak`, `ld_misalign`, `st_misalign`, `mret_mem`  in  1 each  MEM exception/mret flags
- `ext_irq`  in  1  external interrupt, asynchronous level
- `mstatus`  in  32  from CSR file; bit 3 = MIE
- `mtvec_in`, `mepc_in`  in  32  current CSR values
- `trap`, `mret`  out  1  CSR update strobes
- `mepc_out`, `mcause_out`, `mtval_out`  out  32  CSR write data
- `flush`  out  1  kill IF..WB, including the MEM instruction and its CSR write
- `redirect`  out  1  load PC from `redirect_pc`
- `redirect_pc`  out  32  target

## Operation
- FSM states: IDLE, TRAP, RET, REDIRECT. All transitions occur on `clk`.
- In IDLE with `valid_mem` set, events are taken in this priority order:
  - interrupt (`irq_pend & mstatus[3]`): cause 0x8000000B, mtval 0
  - inst_misalign: cause 0, mtval = pc
  - illegal: cause 2, mtval = inst
  - ebreak: cause 3, mtval = pc
  - ecall: cause 11, mtval 0
  - ld_misalign: cause 4, mtval = addr
  - st_misalign: cause 6, mtval = addr
  - mret_mem (no other event pending)
- Exception or interrupt: latch pc, cause and mtval; go to TRAP.
- mret: go to RET.
- TRAP: `trap`=1 with the latched values, `mepc_out`=latched pc. Go to REDIRECT with target from `mtvec_in`.
- RET: `mret`=1, `mepc_out`=`mepc_in`, `mcause_out`=0, `mtval_out`=0. Go to REDIRECT with target `mepc_in`.
- REDIRECT: `redirect`=1, `redirect_pc`=latched target. Go to IDLE.
- Interrupt pending latch:
  - set on a rising edge of the synchronised `ext_irq`
  - cleared when the interrupt is taken
  - held while MIE=0 or FSM not in IDLE
- `flush` = (IDLE and an event is taken this cycle, combinational) OR (state ≠ IDLE).
- MEM flags are ignored outside IDLE.
- Trap target: `{mtvec_in[31:2],2'b00}`, except as modified under Configuration.

## Timing
- Reset: state IDLE, pending latch 0, synchroniser 0. All outputs 0.
- Event detected in MEM at cycle N:
  - `flush` high in N, N+1, N+2
  - `trap`/`mret` high in N+1 only
  - `redirect` high in N+2 only
  - IDLE again at N+3, where new events can be taken
- `ext_irq` to pending latch: 3 cycles (2-flop synchroniser + edge register).
- Exception and interrupt in the same cycle: interrupt wins; `mepc` = `pc_mem`, and the instruction re-executes after the handler.
- `rst` mid-sequence: immediate return to IDLE with all outputs 0, including any in-flight `trap`/`redirect`.

## Configuration
- `TRAP_VECTORED_EN` defined, `mtvec_in[1:0]`==1 and the event is an interrupt: target = `{mtvec_in[31:2],2'b00} + 4*cause[30:0]`. Exceptions always use the base address.
- `TRAP_VECTORED_EN` undefined: `mtvec_in[1:0]` is ignored and the target is always the base address.

## Structure
- Shared constants in the shared macro header/package:
  - cause codes (`CAUSE_ILLEGAL`, `CAUSE_ECALL_M`, `CAUSE_M_EXT_IRQ`, ...)
  - FSM state encodings
  - `MSTATUS_MIE` bit index
- One sub-module, `irq_sync`: 2-flop synchroniser plus rising-edge pulse, with async reset.

## Test plan
- `illegal` with pc 0x100, inst 0xFFFFFFFF, mtvec 0x200:
  - `trap` at N+1 with cause 2, mtval 0xFFFFFFFF, mepc 0x100
  - redirect to 0x200 at N+2
- `ecall` and `ld_misalign` together, mem_addr 0x1003: cause 11 and mtval 0 (ecall wins).
- `mret_mem` with mepc_in 0x104: `mret` at N+1 with mcause_out 0, redirect 0x104 at N+2, `flush` high N..N+2.
- `ext_irq` rises with MIE=1, pc_mem 0x40, mtvec 0x201, macro on: cause 0x8000000B, redirect 0x22C. With the macro off: redirect 0x200.
- `ext_irq` with MIE=0: no trap. Setting MIE=1 later: trap taken, then pending latch clears.
- `rst` asserted at N+1 of a trap: `trap` and `redirect` never seen afterwards, FSM in IDLE.
